glyph_match_scorer: RTL and testbench
=====================================

// Module: glyph_match_scorer
// PURPOSE
//  Downstream consumer of the 16x16 operator/digit glyph ROMs. On start, walks rows 0..15.
//  Each cycle it reads one template row from the glyph ROM and the same row of the user-drawn
//  sample bitmap. It accumulates the Hamming distance (popcount of the XOR) into a score.
//  It then flags a match against a threshold. The recognition controller runs one instance
//  per template and picks the best score.
// PARAMETERS
//  ROWS     16  rows per glyph; also the scan length (row counter is 4 bits)
//  WIDTH    16  pixels per row; row bit 0 = leftmost pixel
//  SCORE_W  9   score width; must hold ROWS*WIDTH = 256
//  THRESH   40  match asserted when score <= THRESH
// PORTS
//  clk         in   1        system clock; all state changes on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        request a scan; sampled only in IDLE
//  rom_addr    out  4        row address to glyph ROM (addr port)
//  rom_char    in   [0:15]   template row; combinational from rom_addr, valid same cycle
//  sample_addr out  4        row address to sample bitmap buffer; always equals rom_addr
//  sample_row  in   [0:15]   drawn row; combinational from sample_addr, valid same cycle
//  busy        out  1        high in SCAN and DONE
//  done        out  1        one-cycle pulse when score/match are updated
//  score       out  SCORE_W  Hamming distance from the last completed scan
//  match       out  1        (score <= THRESH) for the last completed scan
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE; row=0; acc=0; score=0; match=0; done=0; busy=0.
//   - rom_addr and sample_addr = 0.
//  FSM states: IDLE, SCAN, DONE
//   - IDLE: start=1 -> row<=0, acc<=0, go to SCAN. start=0 -> stay.
//   - SCAN: acc <= acc + popcount(rom_char ^ sample_row) for the current row.
//     - row<15: row <= row+1, stay in SCAN.
//     - row==15: score <= acc + final term, match <= (that sum <= THRESH), go to DONE.
//   - DONE: done=1 for exactly this cycle; next cycle return to IDLE.
//  Address outputs: rom_addr = sample_addr = row in SCAN; 0 in IDLE and DONE.
//  Latency (start high in cycle T, in IDLE)
//   - SCAN occupies cycles T+1..T+16.
//   - score, match and done are visible in T+17.
//   - The earliest next start is accepted in T+18.
//  Widths: per-row popcount is 5 bits (0..16); acc and score are SCORE_W bits. No overflow
//   is possible when SCORE_W >= log2(ROWS*WIDTH)+1.
//  start while busy: ignored; it is neither queued nor allowed to restart the scan.
//  score and match hold their values until the next scan completes. A scan in progress
//   never disturbs the visible score.
//  Reset mid-scan: the scan is aborted and all outputs go to their reset values immediately.
//   No done pulse is produced.
//  Sample buffer writes during a scan are not guarded. The controller must not draw while
//   busy=1.
// TESTING (template = '+' glyph: rows 0-5 and 9-15 = 0000001110000000; rows 6-8 = all ones)
//  1. Sample identical to the '+' glyph; start 1 cycle -> done at T+17, score=0, match=1.
//  2. All-zero sample -> score=87 (13 rows x 3 + 3 rows x 16), match=0.
//  3. All-ones sample -> score=169 (256-87), match=0.
//  4. '+' glyph with only row 15 bit 0 flipped -> score=1, match=1. Checks that the last row
//     is included and bit ordering is correct.
//  5. Second start pulse during SCAN (T+5) -> still exactly one done at T+17 and the
//     score is unchanged.
//  6. rst_n low at T+8 of a scan that had a prior score of 87 -> score=0, busy=0.
//     No done pulse follows. A fresh start then completes normally.

Source files
------------

// File: rtl/glyph_match_scorer_if.sv
// rtl/glyph_match_scorer_if.sv - scorer-to-glyph-ROM/sample-buffer/controller signal bundle
interface glyph_match_scorer_if #(
    parameter int ADDR_W  = 4,
    parameter int WIDTH   = 16,
    parameter int SCORE_W = 9
);
    logic               start;
    logic [ADDR_W-1:0]  rom_addr;
    logic [0:WIDTH-1]   rom_char;
    logic [ADDR_W-1:0]  sample_addr;
    logic [0:WIDTH-1]   sample_row;
    logic               busy;
    logic               done;
    logic [SCORE_W-1:0] score;
    logic               match;

    // master is the recognition-controller side that also hosts the ROM and sample buffer
    modport master (
        output start, rom_char, sample_row,
        input  rom_addr, sample_addr, busy, done, score, match
    );

    modport slave (
        input  start, rom_char, sample_row,
        output rom_addr, sample_addr, busy, done, score, match
    );
endinterface

// File: rtl/glyph_match_scorer.sv
// rtl/glyph_match_scorer.sv - Hamming-distance scorer of a sample bitmap against one glyph template
module glyph_match_scorer #(
    parameter int ROWS    = 16,
    parameter int WIDTH   = 16,
    parameter int SCORE_W = 9,
    parameter int THRESH  = 40
) (
    input  logic clk,
    input  logic rst_n,
    glyph_match_scorer_if.slave bus
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int PC_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [SCORE_W-1:0] acc_q, acc_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               match_q, match_d;

    logic [PC_W-1:0]    row_term;
    logic [SCORE_W-1:0] acc_sum;

    function automatic logic [PC_W-1:0] popcount(input logic [0:WIDTH-1] v);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + PC_W'(v[i]);
        end
        return cnt;
    endfunction

    assign row_term = popcount(bus.rom_char ^ bus.sample_row);
    assign acc_sum  = acc_q + SCORE_W'(row_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            acc_q   <= '0;
            score_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            score_q <= score_d;
            match_q <= match_d;
        end
    end

    // score/match only move on the last row, so a running scan never disturbs them
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        acc_d   = acc_q;
        score_d = score_q;
        match_d = match_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    row_d   = '0;
                    acc_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                acc_d = acc_sum;
                if (row_q == ROW_W'(ROWS - 1)) begin
                    score_d = acc_sum;
                    match_d = (acc_sum <= SCORE_W'(THRESH));
                    state_d = DONE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rom_addr    = (state_q == SCAN) ? row_q : '0;
    assign bus.sample_addr = bus.rom_addr;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.score       = score_q;
    assign bus.match       = match_q;
endmodule

// File: tb/tb_glyph_match_scorer.sv
// tb/tb_glyph_match_scorer.sv - directed table-driven bench for glyph_match_scorer against a '+' template
module tb_glyph_match_scorer;
    logic clk;
    logic rst_n;

    glyph_match_scorer_if #(.ADDR_W(4), .WIDTH(16), .SCORE_W(9)) bus ();

    glyph_match_scorer #(.ROWS(16), .WIDTH(16), .SCORE_W(9), .THRESH(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:15] plus_row(input int r);
        logic [0:15] stem;
        stem = 16'b0000001110000000;
        return (r >= 6 && r <= 8) ? 16'hFFFF : stem;
    endfunction

    logic [0:15] sample_mem [16];
    assign bus.rom_char   = plus_row(int'(bus.rom_addr));
    assign bus.sample_row = sample_mem[bus.sample_addr];

    typedef struct {
        string             name;
        logic [15:0][0:15] smp;
        logic [8:0]        exp_score;
        logic              exp_match;
    } vec_t;

    vec_t vecs [7];
    int tests  = 0;
    int failed = 0;
    logic [8:0] prev_score;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0][0:15] smp);
        for (int r = 0; r < 16; r++) sample_mem[r] = smp[r];
    endtask

    // entered #1 after an edge with the DUT idle; extra>0 raises start again in cycle T+extra
    task automatic run_scan(input string name, input logic [8:0] exp_score,
                            input logic exp_match, input int extra);
        int   cyc;
        int   ndone;
        logic addr_ok;
        logic hold_ok;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc     = 1;
        addr_ok = 1'b1;
        hold_ok = 1'b1;
        while (!bus.done && cyc < 40) begin
            if (bus.score !== prev_score) hold_ok = 1'b0;
            if (bus.rom_addr !== 4'(cyc - 1) || bus.sample_addr !== bus.rom_addr || bus.busy !== 1'b1)
                addr_ok = 1'b0;
            bus.start = (cyc == extra);
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check({name, "_latency"}, cyc, 17);
        check({name, "_score"}, bus.score, exp_score);
        check({name, "_match"}, bus.match, exp_match);
        check({name, "_busy_done"}, bus.busy, 1);
        check({name, "_addr_seq"}, addr_ok, 1);
        check({name, "_score_hold"}, hold_ok, 1);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
            if (i == 0) check({name, "_idle_busy"}, bus.busy, 0);
        end
        check({name, "_single_done"}, ndone, 0);
        check({name, "_score_kept"}, bus.score, exp_score);
        prev_score = exp_score;
    endtask

    initial begin
        int ndone;
        for (int v = 0; v < 7; v++)
            for (int r = 0; r < 16; r++) vecs[v].smp[r] = plus_row(r);
        vecs[0].name = "plus_exact";  vecs[0].exp_score = 9'd0;   vecs[0].exp_match = 1'b1;
        vecs[1].name = "all_zero";    vecs[1].exp_score = 9'd87;  vecs[1].exp_match = 1'b0;
        for (int r = 0; r < 16; r++) vecs[1].smp[r] = 16'h0000;
        vecs[2].name = "all_ones";    vecs[2].exp_score = 9'd169; vecs[2].exp_match = 1'b0;
        for (int r = 0; r < 16; r++) vecs[2].smp[r] = 16'hFFFF;
        vecs[3].name = "last_row_b0"; vecs[3].exp_score = 9'd1;   vecs[3].exp_match = 1'b1;
        vecs[3].smp[15][0] = 1'b1;
        vecs[4].name = "thresh_40";   vecs[4].exp_score = 9'd40;  vecs[4].exp_match = 1'b1;
        vecs[4].smp[0] = 16'h0000; vecs[4].smp[1] = 16'h0000;
        vecs[4].smp[7] = 16'h0000; vecs[4].smp[8] = 16'h0000;
        vecs[4].smp[2][0] = 1'b1;  vecs[4].smp[2][1] = 1'b1;
        vecs[5] = vecs[4];
        vecs[5].name = "thresh_41";   vecs[5].exp_score = 9'd41;  vecs[5].exp_match = 1'b0;
        vecs[5].smp[3][15] = 1'b1;
        vecs[6].name = "top_blank";   vecs[6].exp_score = 9'd18;  vecs[6].exp_match = 1'b1;
        for (int r = 0; r < 6; r++) vecs[6].smp[r] = 16'h0000;

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        prev_score = 9'd0;
        for (int r = 0; r < 16; r++) sample_mem[r] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_score", bus.score, 0);
        check("rst_match", bus.match, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr", {bus.rom_addr, bus.sample_addr}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            load(vecs[v].smp);
            run_scan(vecs[v].name, vecs[v].exp_score, vecs[v].exp_match, 0);
        end

        // second start at T+5 must be ignored
        load(vecs[3].smp);
        run_scan("restart_ignored", 9'd1, 1'b1, 5);

        // reset in T+8 of a scan after a prior score of 87
        load(vecs[1].smp);
        run_scan("pre_reset", 9'd87, 1'b0, 0);
        load(vecs[0].smp);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_abort_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_score", bus.score, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_match", bus.match, 0);
        check("abort_addr", bus.rom_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ndone++;
        end
        check("abort_no_done", ndone, 0);
        prev_score = 9'd0;
        load(vecs[1].smp);
        run_scan("post_reset", 9'd87, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
